// File: rtl/data_memory_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and default sizes for the MIPS data memory controller.
//   dmem_state_t : controller state (IDLE accepts commands, CLEAR sweeps
//                  zeros through the array one word per cycle)
//   DMEM_DATA_W  : default word width in bits
//   DMEM_ADDR_W  : default address width (depth is 2**DMEM_ADDR_W words)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 8;

    typedef enum logic {
        DMEM_IDLE  = 1'b0,
        DMEM_CLEAR = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl_if
// Command/response bundle between the MEM stage and the data memory.
//   clear      : request a zero sweep of the whole array
//   mem_read   : read command
//   mem_write  : write command
//   address    : word address
//   write_data : store data
//   ready      : controller accepts commands this cycle
//   read_data  : registered load result, held between reads
//   read_valid : one-cycle strobe marking read_data as fresh
// Modports: master (MEM stage side), slave (memory controller side).
// ---------------------------------------------------------------------------
interface data_memory_ctrl_if
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
);

    logic              clear;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;

    modport master (
        output clear, mem_read, mem_write, address, write_data,
        input  ready, read_data, read_valid
    );

    modport slave (
        input  clear, mem_read, mem_write, address, write_data,
        output ready, read_data, read_valid
    );

endinterface

// File: rtl/data_memory_ctrl_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, written so synthesis can map it onto block
// RAM: one write port, one registered read port, no reset on storage or on
// the output register.
//   clk   : rising-edge clock
//   we    : write enable
//   re    : read enable (loads the output register)
//   addr  : shared word address
//   wdata : write data
//   rdata : registered read data, write-first on a same-cycle write
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-first: a read of the word being written returns the new data,
    // so the bypass is taken from wdata rather than the old array contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
// Parametrised data memory for the MIPS MEM stage. Commands are accepted
// only while ready is high; reads return one cycle after acceptance with a
// read_valid strobe. With DMEM_CLEAR_SWEEP_EN defined, reset (and a clear
// request in IDLE) walks a zero through every word, one per cycle, before
// ready rises. With the macro undefined the controller sits in IDLE, clear
// is ignored and the array powers up with unknown contents.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : data_memory_ctrl_if slave modport (commands in, load data out)
// Parameters: DATA_W word width, ADDR_W address width (DEPTH = 2**ADDR_W).
// Configuration macro: DMEM_CLEAR_SWEEP_EN.
// ---------------------------------------------------------------------------
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    data_memory_ctrl_if.slave bus
);

    dmem_state_t       state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clear_req;

`ifdef DMEM_CLEAR_SWEEP_EN
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    dmem_state_t       state_next;
    logic [ADDR_W-1:0] clr_cnt_next;

    // Reset parks the controller at the start of a sweep, so an interrupted
    // sweep always restarts from word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= DMEM_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            DMEM_CLEAR: begin
                if (clr_cnt == LAST_WORD) begin
                    state_next   = DMEM_IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            DMEM_IDLE: begin
                if (bus.clear) begin
                    state_next = DMEM_CLEAR;
                end
            end
            default: begin
                state_next   = DMEM_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    assign clear_req = bus.clear;
`else
    logic unused_clear;

    assign state        = DMEM_IDLE;
    assign clr_cnt      = '0;
    assign clear_req    = 1'b0;
    assign unused_clear = bus.clear;
`endif

    logic              ready;
    logic              sweeping;
    logic              accept;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              read_valid_q;
    logic              has_data;

    // ready comes straight from the state register; a clear request in the
    // same cycle as a command wins and the command is dropped.
    assign ready    = (state == DMEM_IDLE);
    assign sweeping = (state == DMEM_CLEAR);
    assign accept   = ready & (bus.mem_read | bus.mem_write) & ~clear_req;

    // During a sweep the counter owns the RAM port and writes zero.
    assign arr_we    = sweeping | (accept & bus.mem_write);
    assign arr_re    = accept & bus.mem_read;
    assign arr_addr  = sweeping ? clr_cnt : bus.address;
    assign arr_wdata = sweeping ? '0 : bus.write_data;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The RAM output register has no reset, so has_data masks it to zero
    // from reset until the first accepted read has loaded it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid_q <= 1'b0;
            has_data     <= 1'b0;
        end else begin
            read_valid_q <= arr_re;
            if (arr_re) begin
                has_data <= 1'b1;
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.read_valid = read_valid_q;
    assign bus.read_data  = has_data ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed self-checking bench for data_memory_ctrl with DATA_W=8,
// ADDR_W=4 (16 words). Exercises the clear-sweep build when
// DMEM_CLEAR_SWEEP_EN is defined and the plain build otherwise.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   cycles;

    data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    data_memory_ctrl #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a step never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic clr,
                                 input logic [3:0] addr, input logic [7:0] wdata);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.clear      = clr;
        bus.address    = addr;
        bus.write_data = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

`ifdef DMEM_CLEAR_SWEEP_EN
    // Clock until ready rises (bounded), reporting edges taken and whether
    // any read_valid appeared while the controller was busy.
    task automatic waitReady(output int edges, output logic saw_valid);
        edges     = 0;
        saw_valid = 1'b0;
        do begin
            stepClock();
            edges++;
            if (bus.read_valid) saw_valid = 1'b1;
        end while (!bus.ready && edges < 40);
    endtask
`endif

    initial begin
`ifdef DMEM_CLEAR_SWEEP_EN
        int   edges;
        logic saw_valid;
`endif
        checks   = 0;
        failures = 0;
        cycles   = 0;
        reset_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) stepClock();

`ifdef DMEM_CLEAR_SWEEP_EN
        $display("[TB] clear-sweep build");
        checkOutput("reset_ready", 32'(bus.ready), 32'h0);
        checkOutput("reset_read_valid", 32'(bus.read_valid), 32'h0);
        checkOutput("reset_read_data", 32'(bus.read_data), 32'h00);

        // Reset sweep: ready low for the 16 sweep edges.
        reset_n = 1'b1;
        checkOutput("sweep_ready_low", 32'(bus.ready), 32'h0);
        waitReady(edges, saw_valid);
        checkOutput("reset_sweep_edges", 32'(edges), 32'd16);

        // Back-to-back reads of every word return zero.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
            stepClock();
            checkOutput($sformatf("sweep_rv_%0d", i), 32'(bus.read_valid), 32'h1);
            checkOutput($sformatf("sweep_rd_%0d", i), 32'(bus.read_data), 32'h00);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        stepClock();
        checkOutput("sweep_rv_end", 32'(bus.read_valid), 32'h0);

        // Write then read.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5);
        stepClock();
        checkOutput("write_no_valid", 32'(bus.read_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        stepClock();
        checkOutput("wr_rd_valid", 32'(bus.read_valid), 32'h1);
        checkOutput("wr_rd_data", 32'(bus.read_data), 32'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        stepClock();
        checkOutput("wr_rd_single_pulse", 32'(bus.read_valid), 32'h0);
        checkOutput("wr_rd_hold", 32'(bus.read_data), 32'hA5);

        // Same-cycle read and write, write-first.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 8'h3C);
        stepClock();
        checkOutput("rw_same_valid", 32'(bus.read_valid), 32'h1);
        checkOutput("rw_same_data", 32'(bus.read_data), 32'h3C);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        stepClock();
        checkOutput("rw_same_stored", 32'(bus.read_data), 32'h3C);

        // Clear during traffic: the write issued with clear is dropped.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 8'hFF);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, 8'h11);
        stepClock();
        checkOutput("clear_ready_low", 32'(bus.ready), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
        waitReady(edges, saw_valid);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("clear_sweep_edges", 32'(edges), 32'd16);
        checkOutput("busy_read_dropped", 32'(saw_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        stepClock();
        checkOutput("cleared_rv_1", 32'(bus.read_valid), 32'h1);
        checkOutput("cleared_rd_1", 32'(bus.read_data), 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        stepClock();
        checkOutput("cleared_rd_2", 32'(bus.read_data), 32'h00);

        // Reset mid-sweep restarts a full sweep.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd12, 8'h77);
        stepClock();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd12, 8'h00);
        stepClock();
        checkOutput("pre_reset_rd", 32'(bus.read_data), 32'h77);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (8) stepClock();
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(bus.ready), 32'h0);
        checkOutput("midreset_rv", 32'(bus.read_valid), 32'h0);
        checkOutput("midreset_rd", 32'(bus.read_data), 32'h00);
        stepClock();
        reset_n = 1'b1;
        waitReady(edges, saw_valid);
        checkOutput("midreset_sweep_edges", 32'(edges), 32'd16);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd12, 8'h00);
        stepClock();
        checkOutput("midreset_cleared_rv", 32'(bus.read_valid), 32'h1);
        checkOutput("midreset_cleared_rd", 32'(bus.read_data), 32'h00);
`else
        $display("[TB] plain build");
        checkOutput("reset_ready", 32'(bus.ready), 32'h1);
        checkOutput("reset_read_valid", 32'(bus.read_valid), 32'h0);
        checkOutput("reset_read_data", 32'(bus.read_data), 32'h00);

        reset_n = 1'b1;
        stepClock();
        checkOutput("ready_first_cycle", 32'(bus.ready), 32'h1);

        // Write then read at the top word.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd15, 8'h5A);
        stepClock();
        checkOutput("write_no_valid", 32'(bus.read_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd15, 8'h00);
        stepClock();
        checkOutput("wr_rd_valid", 32'(bus.read_valid), 32'h1);
        checkOutput("wr_rd_data", 32'(bus.read_data), 32'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        stepClock();
        checkOutput("wr_rd_single_pulse", 32'(bus.read_valid), 32'h0);
        checkOutput("wr_rd_hold", 32'(bus.read_data), 32'h5A);

        // clear is ignored: ready stays high and the write lands.
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, 8'h11);
        stepClock();
        checkOutput("clear_ignored_ready", 32'(bus.ready), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        stepClock();
        checkOutput("clear_ignored_rd", 32'(bus.read_data), 32'h11);

        // Same-cycle read and write, write-first.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 8'h3C);
        stepClock();
        checkOutput("rw_same_valid", 32'(bus.read_valid), 32'h1);
        checkOutput("rw_same_data", 32'(bus.read_data), 32'h3C);

        // Fill words 8..11 then read them back on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'(8 + i), 8'(8'hC0 + i * 8'h11));
            stepClock();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'(8 + i), 8'h00);
            stepClock();
            checkOutput($sformatf("b2b_rv_%0d", i), 32'(bus.read_valid), 32'h1);
            checkOutput($sformatf("b2b_rd_%0d", i), 32'(bus.read_data), 32'(8'hC0 + i * 8'h11));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        stepClock();
        checkOutput("b2b_rv_end", 32'(bus.read_valid), 32'h0);
        checkOutput("b2b_hold", 32'(bus.read_data), 32'hF3);

        // Earlier words survive later traffic.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd15, 8'h00);
        stepClock();
        checkOutput("reread_15", 32'(bus.read_data), 32'h5A);

        // Reset zeroes the outputs but keeps ready high.
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(bus.ready), 32'h1);
        checkOutput("midreset_rv", 32'(bus.read_valid), 32'h0);
        checkOutput("midreset_rd", 32'(bus.read_data), 32'h00);
        stepClock();
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        stepClock();
        checkOutput("post_reset_rd", 32'(bus.read_data), 32'h3C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
